// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
//   seq_state_e : sequencer FSM states
//   BR_PAGE     : branch_rel value selecting a page-absolute target
//   BR_REL      : branch_rel value selecting a PC-relative signed target
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    HALT  = 2'd3
  } seq_state_e;

  localparam logic BR_PAGE = 1'b0;
  localparam logic BR_REL  = 1'b1;

endpackage

// File: rtl/pc_ret_stack.sv
// Small LIFO holding call return addresses.
//   clk, reset_n : clock, async active-low reset
//   clear        : synchronous flush (priority over push/pop)
//   push, din    : store din on top (never asserted together with pop)
//   pop          : discard the top entry
//   top          : current top entry (valid when !empty)
//   empty, full  : occupancy flags
module pc_ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 11
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  // Read from one below the count; the value is a don't-care when empty.
  assign top   = mem[AW'(cnt - CW'(1))];

  // Occupancy counter and storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (push) begin
      mem[AW'(cnt)] <= din;
      cnt           <= cnt + CW'(1);
    end else if (pop) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: program start select, conditional page/relative
// branches, call/return via a hardware return stack, run/halt handshake.
//   clk, reset_n         : clock, async active-low reset
//   start, prog_sel      : load selected program base (level-sensitive)
//   branch_en, ALU_flag  : conditional branch request and condition
//   branch_rel, target   : branch mode and target field
//   call_en, ret_en      : call to page target / return to stacked address
//   halt_in              : program-end instruction decoded
//   prog_ctr             : instruction ROM address
//   running, done        : state is RUN / HALT
//   stack_err            : sticky return-stack overflow/underflow
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W      = 11,
  parameter int unsigned TGT_W     = 6,
  parameter int unsigned NUM_PROG  = 3,
  parameter logic [NUM_PROG*PC_W-1:0] PROG_BASE = {11'h200, 11'h100, 11'h000},
  parameter int unsigned RAS_DEPTH = 4,
  localparam int unsigned SEL_W    = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [SEL_W-1:0] prog_sel,
  input  logic             branch_en,
  input  logic             ALU_flag,
  input  logic             branch_rel,
  input  logic [TGT_W-1:0] target,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic             halt_in,
  output logic [PC_W-1:0]  prog_ctr,
  output logic             running,
  output logic             done,
  output logic             stack_err
);

  seq_state_e      state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            err_nxt;
  logic [PC_W-1:0] base_c;
  logic [PC_W-1:0] page_tgt_c;
  logic [PC_W-1:0] rel_tgt_c;
  logic [PC_W-1:0] stk_top;
  logic            stk_empty, stk_full;
  logic            stk_push, stk_pop, stk_clear;

  // Out-of-range program indices fall back to base 0.
  always_comb begin
    base_c = '0;
    for (int i = 0; i < int'(NUM_PROG); i++) begin
      if (prog_sel == SEL_W'(i)) base_c = PROG_BASE[i*PC_W +: PC_W];
    end
  end

  assign page_tgt_c = {prog_ctr[PC_W-1:TGT_W], target};
  assign rel_tgt_c  = prog_ctr + {{(PC_W-TGT_W){target[TGT_W-1]}}, target};

  pc_ret_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (stk_clear),
    .push    (stk_push),
    .pop     (stk_pop),
    .din     (prog_ctr + PC_W'(1)),
    .top     (stk_top),
    .empty   (stk_empty),
    .full    (stk_full)
  );

  // State, PC and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      prog_ctr  <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      prog_ctr  <= pc_nxt;
      running   <= (state_nxt == RUN);
      done      <= (state_nxt == HALT);
      stack_err <= err_nxt;
    end
  end

  // Next-state, next-PC and stack control.
  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
    err_nxt   = stack_err;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clear = 1'b0;

    if (start) begin
      state_nxt = ARMED;
      pc_nxt    = base_c;
      err_nxt   = 1'b0;
      stk_clear = 1'b1;
    end else begin
      unique case (state)
        ARMED: state_nxt = RUN;
        RUN: begin
          if (halt_in) begin
            state_nxt = HALT;
          end else if (ret_en) begin
            if (stk_empty) begin
              err_nxt   = 1'b1;
              state_nxt = HALT;
            end else begin
              pc_nxt  = stk_top;
              stk_pop = 1'b1;
            end
          end else if (call_en) begin
            if (stk_full) begin
              err_nxt   = 1'b1;
              state_nxt = HALT;
            end else begin
              pc_nxt   = page_tgt_c;
              stk_push = 1'b1;
            end
          end else if (branch_en && ALU_flag) begin
            pc_nxt = (branch_rel == BR_REL) ? rel_tgt_c : page_tgt_c;
          end else begin
            pc_nxt = prog_ctr + PC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by a
// randomized phase, all compared against an integer/queue reference model.
module tb_pc_sequencer;

  localparam int PC_MOD = 2048;
  localparam int DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  prog_sel;
  logic        branch_en;
  logic        alu_flag;
  logic        branch_rel;
  logic [5:0]  target;
  logic        call_en;
  logic        ret_en;
  logic        halt_in;
  logic [10:0] prog_ctr;
  logic        running;
  logic        done;
  logic        stack_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 armed, 2 run, 3 halt.
  int m_pc;
  int m_mode;
  bit m_err;
  int m_stk[$];

  pc_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .prog_sel   (prog_sel),
    .branch_en  (branch_en),
    .ALU_flag   (alu_flag),
    .branch_rel (branch_rel),
    .target     (target),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .halt_in    (halt_in),
    .prog_ctr   (prog_ctr),
    .running    (running),
    .done       (done),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  function automatic int base_of(input int sel);
    case (sel)
      1:       return 256;
      2:       return 512;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc   = 0;
    m_mode = 0;
    m_err  = 1'b0;
    m_stk.delete();
  endtask

  task automatic model_update();
    int t;
    t = int'(target);
    if (start) begin
      m_pc   = base_of(int'(prog_sel));
      m_mode = 1;
      m_err  = 1'b0;
      m_stk.delete();
    end else if (m_mode == 1) begin
      m_mode = 2;
    end else if (m_mode == 2) begin
      if (halt_in) begin
        m_mode = 3;
      end else if (ret_en) begin
        if (m_stk.size() == 0) begin
          m_err  = 1'b1;
          m_mode = 3;
        end else begin
          m_pc = m_stk.pop_back();
        end
      end else if (call_en) begin
        if (m_stk.size() == DEPTH) begin
          m_err  = 1'b1;
          m_mode = 3;
        end else begin
          m_stk.push_back((m_pc + 1) % PC_MOD);
          m_pc = (m_pc / 64) * 64 + t;
        end
      end else if (branch_en && alu_flag) begin
        if (branch_rel) m_pc = (m_pc + (t >= 32 ? t - 64 : t) + PC_MOD) % PC_MOD;
        else            m_pc = (m_pc / 64) * 64 + t;
      end else begin
        m_pc = (m_pc + 1) % PC_MOD;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},      32'(prog_ctr),  32'(m_pc));
    chk({tag, ".running"}, 32'(running),   32'(m_mode == 2));
    chk({tag, ".done"},    32'(done),      32'(m_mode == 3));
    chk({tag, ".err"},     32'(stack_err), 32'(m_err));
  endtask

  task automatic set_ctl(input bit s, input int sel, input bit be, input bit af,
                         input bit br, input int tg, input bit ce, input bit re,
                         input bit hi);
    start      = s;
    prog_sel   = 2'(sel);
    branch_en  = be;
    alu_flag   = af;
    branch_rel = br;
    target     = 6'(tg);
    call_en    = ce;
    ret_en     = re;
    halt_in    = hi;
  endtask

  task automatic idle_ctl();
    set_ctl(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step(input string tag);
    model_update();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    reset_n = 1'b1;
    idle_ctl();
    #1 reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_model("reset");
    chk("reset.pc_zero", 32'(prog_ctr), 32'h0);
    reset_n = 1'b1;

    // Hold start for three cycles on program 1.
    set_ctl(1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("start_hold");
      chk("start_hold.base", 32'(prog_ctr), 32'h100);
    end
    idle_ctl();
    step("armed_to_run");
    chk("first_run.pc", 32'(prog_ctr), 32'h100);
    chk("first_run.running", 32'(running), 32'h1);
    step("adv1");
    chk("adv1.pc", 32'(prog_ctr), 32'h101);
    step("adv2");
    chk("adv2.pc", 32'(prog_ctr), 32'h102);

    // Branch cases around 0x105.
    set_ctl(0, 0, 1, 1, 0, 6'h05, 0, 0, 0); step("to_105");
    set_ctl(0, 0, 1, 1, 1, 6'h3C, 0, 0, 0); step("rel_m4");
    chk("rel_m4.pc", 32'(prog_ctr), 32'h101);
    set_ctl(0, 0, 1, 1, 0, 6'h05, 0, 0, 0); step("to_105b");
    set_ctl(0, 0, 1, 0, 1, 6'h3C, 0, 0, 0); step("not_taken");
    chk("not_taken.pc", 32'(prog_ctr), 32'h106);
    set_ctl(0, 0, 1, 1, 0, 6'h0A, 0, 0, 0); step("page_0a");
    chk("page_0a.pc", 32'(prog_ctr), 32'h10A);

    // Call at 0x120 then return.
    set_ctl(0, 0, 1, 1, 0, 6'h20, 0, 0, 0); step("to_120");
    set_ctl(0, 0, 0, 0, 0, 6'h05, 1, 0, 0); step("call");
    chk("call.pc", 32'(prog_ctr), 32'h105);
    set_ctl(0, 0, 0, 0, 0, 0, 0, 1, 0); step("ret");
    chk("ret.pc", 32'(prog_ctr), 32'h121);

    // Five nested calls overflow a four-deep stack.
    set_ctl(0, 0, 0, 0, 0, 6'h05, 1, 0, 0);
    for (int i = 0; i < 5; i++) step("nest");
    chk("overflow.err", 32'(stack_err), 32'h1);
    chk("overflow.done", 32'(done), 32'h1);
    chk("overflow.pc", 32'(prog_ctr), 32'h105);
    idle_ctl();
    for (int i = 0; i < 3; i++) step("halt_hold");

    // Return with empty stack at the start of a run.
    set_ctl(1, 0, 0, 0, 0, 0, 0, 0, 0); step("restart0");
    set_ctl(0, 0, 0, 0, 0, 0, 0, 1, 0); step("armed_ret_ignored");
    step("underflow");
    chk("underflow.err", 32'(stack_err), 32'h1);
    chk("underflow.done", 32'(done), 32'h1);
    set_ctl(1, 0, 0, 0, 0, 0, 0, 0, 0); step("clear_err");
    chk("clear_err.err", 32'(stack_err), 32'h0);
    idle_ctl(); step("run0");

    // Wrap from 0x7FF to 0, then halt at 0x10.
    set_ctl(0, 0, 1, 1, 1, 6'h3F, 0, 0, 0); step("to_7ff");
    chk("to_7ff.pc", 32'(prog_ctr), 32'h7FF);
    idle_ctl(); step("wrap");
    chk("wrap.pc", 32'(prog_ctr), 32'h000);
    set_ctl(0, 0, 1, 1, 0, 6'h10, 0, 0, 0); step("to_10");
    set_ctl(0, 0, 0, 0, 0, 0, 0, 0, 1); step("halt");
    idle_ctl();
    for (int i = 0; i < 10; i++) begin
      step("halted");
      chk("halted.pc", 32'(prog_ctr), 32'h010);
      chk("halted.running", 32'(running), 32'h0);
    end

    // Out-of-range program select.
    set_ctl(1, 3, 0, 0, 0, 0, 0, 0, 0); step("sel3");
    chk("sel3.pc", 32'(prog_ctr), 32'h000);
    idle_ctl(); step("sel3_run");

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      set_ctl($urandom_range(0, 31) == 0, int'($urandom_range(0, 3)),
              $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 63)), $urandom_range(0, 7) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
      step("rand");
    end

    // Asynchronous reset mid-run.
    set_ctl(1, 2, 0, 0, 0, 0, 0, 0, 0); step("pre_rst_start");
    idle_ctl();
    for (int i = 0; i < 3; i++) step("pre_rst_run");
    chk("pre_rst.running", 32'(running), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    @(posedge clk);
    #1;
    check_model("rst_held");
    reset_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the CSE141L core. It replaces the single-program fetch counter with multi-program start selection, page-absolute and PC-relative conditional branches, and a small hardware return stack for call/return. It also provides an explicit run/halt handshake to the testbench. It sits between the decoder/ALU flag logic and instruction ROM, and drives the ROM address every cycle.

## Interface
- PC_W, 11: program counter width.
- TGT_W, 6: branch/call target field width (TGT_W < PC_W).
- NUM_PROG, 3: number of selectable programs.
- PROG_BASE, {11'h200, 11'h100, 11'h000}: packed NUM_PROG*PC_W start addresses; slice i is the base of program i.
- RAS_DEPTH, 4: return-stack entries.
- clk  in  1  sole clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  load selected program base and hold while high.
- prog_sel  in  SEL_W=max(1,$clog2(NUM_PROG))  program index, sampled while start=1.
- branch_en  in  1  conditional branch request.
- ALU_flag  in  1  branch condition.
- branch_rel  in  1  0: page-absolute target, 1: PC-relative signed target.
- target  in  TGT_W  branch/call target field.
- call_en  in  1  call to page-absolute target.
- ret_en  in  1  return to popped address.
- halt_in  in  1  program-end instruction decoded.
- prog_ctr  out  PC_W  current instruction address.
- running  out  1  state is RUN.
- done  out  1  state is HALT.
- stack_err  out  1  sticky overflow/underflow flag.

## Operation
- States: IDLE, ARMED, RUN, HALT.
- Reset (reset_n=0, asynchronous): prog_ctr=0, state IDLE, running=0, done=0, stack_err=0, stack empty.
- start=1 in any state: prog_ctr <= PROG_BASE[prog_sel]; if prog_sel >= NUM_PROG, use base 0. State goes to ARMED, stack is cleared, and stack_err is cleared. start has priority over everything else.
- ARMED with start=0: go to RUN. prog_ctr holds the base on this edge.
- IDLE and HALT with start=0: prog_ctr holds.
- RUN priority, highest first:
  - halt_in: go to HALT; PC holds.
  - ret_en: if stack is empty, set stack_err and go to HALT with PC held; otherwise PC <= top of stack and pop.
  - call_en: if stack is full, set stack_err and go to HALT; otherwise push PC+1 and PC <= {PC[PC_W-1:TGT_W], target}.
  - branch_en && ALU_flag, with branch_rel=0: PC <= {PC[PC_W-1:TGT_W], target}.
  - branch_en && ALU_flag, with branch_rel=1: PC <= PC + sign_extend(target), modulo 2^PC_W.
  - otherwise: PC <= PC+1, wrapping from all-ones to 0.
- Branch requests with ALU_flag=0 are not taken: PC+1.
- The pushed return address PC+1 also wraps modulo 2^PC_W.
- In IDLE, ARMED and HALT, control inputs other than start are ignored.

## Timing
- Every control input is sampled on the rising clk edge; the new prog_ctr is visible after that edge. This is zero-cycle decision latency, one register stage.
- running and done are registered state decodes; they change on the same edge as the state.
- start is level-sensitive. Holding it N cycles keeps prog_ctr at the base. The first instruction executed is the base, on the first edge after start falls (ARMED→RUN edge leaves PC at base; the next edge advances).
- Stack push and pop complete on the same edge as the PC update. A return immediately after a call returns correctly.
- An asynchronous reset assertion mid-RUN clears everything immediately. Release is synchronised by the user; the block does not resynchronise it.

## Structure
- Package pc_seq_pkg holds the state enum (IDLE, ARMED, RUN, HALT) and the branch-mode constants BR_PAGE=1'b0 and BR_REL=1'b1.
- Sub-module pc_ret_stack is a LIFO with parameters DEPTH and W. Ports: push, pop, din, top, empty, full, clear, plus async active-low reset. Push and pop are never asserted together.
- Top level holds the FSM, next-PC mux and base-select logic.

## Test plan
- Reset, then start=1 with prog_sel=1 for 3 cycles, then release → prog_ctr=0x100 through ARMED and the first RUN cycle, then 0x101, 0x102; running=1.
- At PC=0x105, branch_en=1, ALU_flag=1, branch_rel=1, target=6'h3C (−4) → 0x101. Same case with ALU_flag=0 → 0x106. Same case with branch_rel=0, target=6'h0A → 0x10A.
- Call at 0x120 with target 0x05 → PC=0x105 with return address 0x121 stacked. Then ret_en → 0x121. Five nested calls with depth 4 → stack_err=1, done=1, PC held.
- ret_en at the start of a run with an empty stack → stack_err=1, state HALT. A following start pulse clears stack_err and reloads the base.
- PC=0x7FF with no control → 0x000. halt_in at 0x10 → done=1, running=0, PC stays 0x10 for 10 cycles.
- Assert reset_n=0 between clock edges mid-RUN → prog_ctr=0 and all flags 0 immediately, before the next edge. prog_sel=3 with start → base 0x000.
